// File: rtl/level_generator.sv
// Level reconstructor: turns rise/fall request pulses into a level with
// minimum high/low hold times. Optional pending-request flag: LEVEL_GEN_PENDING_EN.
module level_generator #(
    parameter int unsigned MIN_HIGH = 4,
    parameter int unsigned MIN_LOW  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rise_req,
    input  logic fall_req,
    output logic out_level,
    output logic out_busy,
    output logic out_drop
);

    typedef enum logic [1:0] {
        LOW_READY  = 2'd0,
        LOW_HOLD   = 2'd1,
        HIGH_READY = 2'd2,
        HIGH_HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] HIGH_LOAD = 8'(MIN_HIGH - 1);
    localparam logic [7:0] LOW_LOAD  = 8'(MIN_LOW - 1);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       busy_q, busy_d;
    logic       drop_q, drop_d;
    logic       pend;

`ifdef LEVEL_GEN_PENDING_EN
    logic pend_d;
`else
    assign pend = 1'b0;
`endif

    logic high, ready, opp, same, go;

    always_comb begin
        high    = (state == HIGH_READY) || (state == HIGH_HOLD);
        ready   = (state == HIGH_READY) || (state == LOW_READY);
        opp     = high ? fall_req : rise_req;
        same    = high ? rise_req : fall_req;
        state_d = state;
        cnt_d   = cnt;
        drop_d  = 1'b0;
        go      = 1'b0;
`ifdef LEVEL_GEN_PENDING_EN
        pend_d  = pend;
`endif

        if (!ready) begin
            if (cnt != '0)
                cnt_d = cnt - 8'd1;
            if (cnt <= 8'd1)
                state_d = high ? HIGH_READY : LOW_READY;
        end

        if (rise_req && fall_req) begin
            drop_d = 1'b1;
        end else if (ready) begin
            // a stored request fires on the first READY cycle unless cancelled now
            go = opp || (pend && !same);
`ifdef LEVEL_GEN_PENDING_EN
            pend_d = 1'b0;
`endif
        end else begin
`ifdef LEVEL_GEN_PENDING_EN
            if (opp)
                pend_d = 1'b1;
            else if (same)
                pend_d = 1'b0;
`else
            if (opp)
                drop_d = 1'b1;
`endif
        end

        if (go) begin
            if (high) begin
                cnt_d   = LOW_LOAD;
                state_d = (LOW_LOAD == '0) ? LOW_READY : LOW_HOLD;
            end else begin
                cnt_d   = HIGH_LOAD;
                state_d = (HIGH_LOAD == '0) ? HIGH_READY : HIGH_HOLD;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOW_READY;
            cnt    <= '0;
            busy_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            busy_q <= busy_d;
            drop_q <= drop_d;
        end
    end

`ifdef LEVEL_GEN_PENDING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pend <= 1'b0;
        else
            pend <= pend_d;
    end
`endif

    assign out_level = (state == HIGH_READY) || (state == HIGH_HOLD);
    assign out_busy  = busy_q;
    assign out_drop  = drop_q;

endmodule

// File: tb/tb_level_generator.sv
// Randomized bench for level_generator against a timestamp-based model of
// the hold rules, plus directed literal checks.
module tb_level_generator;

    localparam int MH = 3;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rise_req = 1'b0;
    logic fall_req = 1'b0;
    logic out_level, out_busy, out_drop;

    int n_cmp = 0;
    int n_fail = 0;

    // model: level, cycle of last change, pending flag, expected drop
    int   cyc = 0;
    int   t_last = -1000;
    logic m_lvl = 1'b0;
    logic m_pend = 1'b0;
    logic m_drop = 1'b0;

    level_generator #(.MIN_HIGH(MH), .MIN_LOW(ML)) dut (
        .clk(clk), .rst_n(rst_n), .rise_req(rise_req), .fall_req(fall_req),
        .out_level(out_level), .out_busy(out_busy), .out_drop(out_drop)
    );

    always #5 clk = ~clk;

    function automatic int hold_of(input logic lvl);
        return lvl ? MH : ML;
    endfunction

    function automatic logic m_busy();
        return (cyc - t_last) < (hold_of(m_lvl) - 1);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 1'b0;
        m_pend = 1'b0;
        m_drop = 1'b0;
        t_last = cyc - 1000;
    endtask

    task automatic model_update(input logic r, input logic f);
        logic ready, opp, same, tog;
        ready  = (cyc - t_last) >= (hold_of(m_lvl) - 1);
        opp    = m_lvl ? f : r;
        same   = m_lvl ? r : f;
        tog    = 1'b0;
        m_drop = 1'b0;
        if (r && f) begin
            m_drop = 1'b1;
        end else if (ready) begin
            tog    = opp || (m_pend && !same);
            m_pend = 1'b0;
        end else if (opp) begin
`ifdef LEVEL_GEN_PENDING_EN
            m_pend = 1'b1;
`else
            m_drop = 1'b1;
`endif
        end else if (same) begin
            m_pend = 1'b0;
        end
        cyc++;
        if (tog) begin
            m_lvl  = ~m_lvl;
            t_last = cyc;
        end
    endtask

    task automatic step(input logic r, input logic f);
        rise_req = r;
        fall_req = f;
        @(posedge clk);
        #1;
        model_update(r, f);
        rise_req = 1'b0;
        fall_req = 1'b0;
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_level", out_level, 1'b0);
        check("async_rst_busy", out_busy, 1'b0);
        check("async_rst_drop", out_drop, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        check("level", out_level, m_lvl);
        check("busy", out_busy, m_busy());
        check("drop", out_drop, m_drop);
    end

    initial begin
        logic pend_on;
`ifdef LEVEL_GEN_PENDING_EN
        pend_on = 1'b1;
`else
        pend_on = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", out_level, 1'b0);
        check("reset_busy", out_busy, 1'b0);
        check("reset_drop", out_drop, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // rise at cycle 0, fall at cycle 1
        step(1'b1, 1'b0);
        check("c1_level", out_level, 1'b1);
        check("c1_busy", out_busy, 1'b1);
        step(1'b0, 1'b1);
        check("c2_level", out_level, 1'b1);
        check("c2_busy", out_busy, 1'b1);
        check("c2_drop", out_drop, ~pend_on);
        step(1'b0, 1'b0);
        check("c3_busy", out_busy, 1'b0);
        check("c3_drop", out_drop, 1'b0);
        step(1'b0, 1'b0);
        check("c4_level", out_level, ~pend_on);
        check("c4_busy", out_busy, pend_on);
        step(1'b0, 1'b0);
        check("c5_busy", out_busy, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // both requests in LOW_READY, then repeated rise while high
        async_reset();
        step(1'b1, 1'b1);
        check("both_level", out_level, 1'b0);
        check("both_drop", out_drop, 1'b1);
        step(1'b0, 1'b0);
        check("both_drop_once", out_drop, 1'b0);
        step(1'b1, 1'b0);
        check("rise_level", out_level, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("repeat_rise_level", out_level, 1'b1);
        check("repeat_rise_drop", out_drop, 1'b0);

        // reset during HIGH_HOLD, then rise after release
        async_reset();
        step(1'b1, 1'b0);
        check("hold_busy", out_busy, 1'b1);
        async_reset();
        step(1'b1, 1'b0);
        check("post_rst_level", out_level, 1'b1);

        // rise, fall, rise: pending (if any) is cancelled
        async_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("cancel_drop", out_drop, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        check("cancel_level", out_level, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                async_reset();
            else
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/level_generator.md
LEVEL_GENERATOR -- requirements
Module: level_generator

Interface
REQ-001 Parameter: MIN_HIGH, default 4, minimum number of cycles out_level SHALL stay high after a rise (legal range 1..255).
REQ-002 Parameter: MIN_LOW, default 4, minimum number of cycles out_level SHALL stay low after a fall (legal range 1..255).
REQ-003 Port: clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Port: rise_req  input  1  one-cycle request to drive out_level high.
REQ-006 Port: fall_req  input  1  one-cycle request to drive out_level low.
REQ-007 Port: out_level  output  1  reconstructed level; registered.
REQ-008 Port: out_busy  output  1  high while the minimum-hold window is running; registered.
REQ-009 Port: out_drop  output  1  one-cycle pulse when a request is discarded; registered.

Function
REQ-010 The FSM SHALL have four states: LOW_READY, LOW_HOLD, HIGH_READY and HIGH_HOLD; out_level SHALL be 1 exactly in HIGH_*.
REQ-011 The hold counter SHALL be 8 bits wide; out_busy SHALL equal (counter != 0).
REQ-012 A level change SHALL load the counter with MIN_HIGH-1 (rise) or MIN_LOW-1 (fall) and enter *_HOLD, or *_READY if the loaded value is 0.
REQ-013 In *_HOLD the counter SHALL decrement once per cycle; the FSM SHALL move to *_READY on the edge where the counter reaches 0.
REQ-014 An opposite-direction request sampled in *_READY SHALL change out_level on the next rising edge (1-cycle latency).
REQ-015 Minimum high time SHALL be exactly MIN_HIGH cycles, and minimum low time exactly MIN_LOW cycles, under back-to-back requests.
REQ-016 A same-direction request (rise_req while high, fall_req while low) SHALL be ignored without an out_drop pulse.
REQ-017 If rise_req and fall_req are high in the same cycle, there SHALL be no level change and out_drop SHALL pulse on the next cycle.
REQ-018 An opposite-direction request sampled in *_HOLD SHALL be handled per REQ-023/REQ-024.
REQ-019 out_drop SHALL be high for exactly one cycle per discarded request.
REQ-020 The counter SHALL NOT wrap: it SHALL stay at 0 in *_READY.

Reset
REQ-021 While rst_n=0, out_level=0, out_busy=0, out_drop=0, counter=0, pending=0, and the state SHALL be LOW_READY.
REQ-022 Assertion of rst_n mid-hold SHALL abort the hold immediately (asynchronously); the first request accepted after release SHALL obey REQ-014.

Configuration
REQ-023 Macro LEVEL_GEN_PENDING_EN: when defined, there SHALL be a one-entry pending flag:
  - an opposite request in *_HOLD sets the flag with no drop;
  - a repeat opposite request while the flag is set is ignored;
  - a same-direction request while the flag is set clears it (cancel);
  - the pending change SHALL execute on the edge after the state enters *_READY, i.e. the level changes exactly at the minimum-hold boundary;
  - simultaneous rise_req and fall_req SHALL still follow REQ-017 and leave the pending flag unchanged.
REQ-024 When LEVEL_GEN_PENDING_EN is undefined: no pending storage; an opposite request in *_HOLD SHALL be discarded with an out_drop pulse on the next cycle.

Verification (MIN_HIGH=3, MIN_LOW=2)
REQ-025 Reset, then rise_req at cycle 0 -> out_level=1 from cycle 1, out_busy=1 for cycles 1-2, 0 from cycle 3.
REQ-026 High via rise_req at cycle 0, fall_req at cycle 1, macro off -> out_drop=1 at cycle 2 only; out_level stays 1.
REQ-027 Same stimulus as REQ-026, macro on -> no drop; out_level falls at cycle 4 (3 cycles high); out_busy=1 at cycle 4, 0 at cycle 5.
REQ-028 Macro on: rise at 0, fall_req at 1, rise_req at 2 -> pending cancelled; out_level stays 1 with no drop.
REQ-029 rise_req and fall_req together in LOW_READY -> out_level stays 0, out_drop=1 for one cycle; a repeated rise_req while high -> no drop and no change.
REQ-030 rst_n driven low mid-cycle during HIGH_HOLD -> out_level=0 and out_busy=0 immediately without a clock edge; after release, rise_req -> out_level=1 one cycle later.
